// File: rtl/if_fetch_unit_pkg.sv
// Shared defaults and types for the instruction-fetch front end.
// Holds the address width, reset PC and queue depth defaults plus the request FSM encoding.
package if_fetch_unit_pkg;

    localparam int          FETCH_ADDR_WIDTH = 32;
    localparam logic [31:0] FETCH_RESET_PC   = 32'h8000_0000;
    localparam int          FETCH_QDEPTH     = 4;

    typedef enum logic [1:0] {
        ST_IDLE             = 2'd0,
        ST_WAIT_RSP         = 2'd1,
        ST_WAIT_RSP_DISCARD = 2'd2
    } fetch_state_e;

    // A request issued from an odd word address only carries one useful word.
    function automatic logic [1:0] rsp_word_cnt(input logic hi_only);
        return hi_only ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/if_fetch_unit_queue.sv
// Circular instruction queue with two write ports, two read ports and synchronous clear.
// Each entry carries a 32-bit instruction word and its PC.
module fetch_queue
    import if_fetch_unit_pkg::*;
#(
    parameter int AW    = FETCH_ADDR_WIDTH,
    parameter int DEPTH = FETCH_QDEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic [1:0]               push_cnt_i,
    input  logic [31:0]              push_inst0_i,
    input  logic [AW-1:0]            push_pc0_i,
    input  logic [31:0]              push_inst1_i,
    input  logic [AW-1:0]            push_pc1_i,
    input  logic [1:0]               pop_cnt_i,
    output logic                     head0_valid_o,
    output logic [31:0]              head0_inst_o,
    output logic [AW-1:0]            head0_pc_o,
    output logic                     head1_valid_o,
    output logic [31:0]              head1_inst_o,
    output logic [AW-1:0]            head1_pc_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   inst_mem [DEPTH];
    logic [AW-1:0] pc_mem   [DEPTH];

    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW-1:0] wr_nxt, rd_nxt;
    logic [CW-1:0] count_q, count_d;

    assign wr_nxt = wr_q + PW'(1);
    assign rd_nxt = rd_q + PW'(1);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (clr_i) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            wr_d    = wr_q + PW'(push_cnt_i);
            rd_d    = rd_q + PW'(pop_cnt_i);
            count_d = count_q + CW'(push_cnt_i) - CW'(pop_cnt_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_i && push_cnt_i != 2'd0) begin
            inst_mem[wr_q] <= push_inst0_i;
            pc_mem[wr_q]   <= push_pc0_i;
        end
        if (!clr_i && push_cnt_i == 2'd2) begin
            inst_mem[wr_nxt] <= push_inst1_i;
            pc_mem[wr_nxt]   <= push_pc1_i;
        end
    end

    assign head0_valid_o = (count_q != '0);
    assign head1_valid_o = (count_q >= CW'(2));
    assign head0_inst_o  = inst_mem[rd_q];
    assign head0_pc_o    = pc_mem[rd_q];
    assign head1_inst_o  = inst_mem[rd_nxt];
    assign head1_pc_o    = pc_mem[rd_nxt];
    assign count_o       = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch front end: owns the fetch PC, issues aligned 8-byte I-cache requests,
// applies redirects and feeds returned words into the decode queue.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH = FETCH_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(FETCH_RESET_PC),
    parameter int                    QDEPTH     = FETCH_QDEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            Ctrl_Stall,
    input  logic                  Csr_ExcpFlag,
    input  logic [ADDR_WIDTH-1:0] Csr_ExcpPC,
    input  logic                  EX_BranchFlag,
    input  logic [ADDR_WIDTH-1:0] EX_BranchPC,
    output logic                  Fetch_Req,
    output logic [ADDR_WIDTH-1:0] Fetch_Addr,
    input  logic                  Icache_Ready,
    input  logic                  Icache_RspValid,
    input  logic [63:0]           Icache_RspData,
    output logic                  Icache_StallReq,
    output logic                  Fetch_Valid_0,
    output logic                  Fetch_Valid_1,
    output logic [31:0]           Fetch_Inst_0,
    output logic [31:0]           Fetch_Inst_1,
    output logic [ADDR_WIDTH-1:0] Fetch_PC_0,
    output logic [ADDR_WIDTH-1:0] Fetch_PC_1,
    input  logic [1:0]            Decode_Take,
    output fetch_state_e          dbg_state_o
);

    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  hi_only_q, hi_only_d;

    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic [ADDR_WIDTH-1:0] aligned_pc;
    logic                  free_ge2;
    logic                  accept;
    logic                  rsp_live;
    logic [1:0]            push_cnt;
    logic [1:0]            pop_cnt;
    logic [31:0]           push_inst0;
    logic [ADDR_WIDTH-1:0] push_pc0;
    logic [CW-1:0]         q_count;
    logic                  unused_stall_bits;

    assign unused_stall_bits = ^Ctrl_Stall[4:2];

    assign redirect = Csr_ExcpFlag | EX_BranchFlag;

    always_comb begin
        redirect_pc      = Csr_ExcpFlag ? Csr_ExcpPC : EX_BranchPC;
        redirect_pc[1:0] = 2'b00;
    end

    assign aligned_pc = {pc_q[ADDR_WIDTH-1:3], 3'b000};
    assign free_ge2   = (CW'(QDEPTH) - q_count) >= CW'(2);

    // Only IDLE may issue, which also guarantees a single outstanding request.
    assign Fetch_Req  = !rst && (state_q == ST_IDLE) && free_ge2 && !Ctrl_Stall[0] && !redirect;
    assign Fetch_Addr = aligned_pc;
    assign accept     = Fetch_Req && Icache_Ready;
    assign rsp_live   = (state_q == ST_WAIT_RSP) && Icache_RspValid;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        hi_only_d  = hi_only_q;
        push_cnt   = 2'd0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_WAIT_RSP;
                    pc_d       = aligned_pc + ADDR_WIDTH'(8);
                    req_addr_d = aligned_pc;
                    hi_only_d  = pc_q[2];
                end
            end
            ST_WAIT_RSP: begin
                if (Icache_RspValid) begin
                    state_d = ST_IDLE;
                    if (!redirect) push_cnt = rsp_word_cnt(hi_only_q);
                end else if (redirect) begin
                    state_d = ST_WAIT_RSP_DISCARD;
                end
            end
            ST_WAIT_RSP_DISCARD: begin
                if (Icache_RspValid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (redirect) pc_d = redirect_pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
            hi_only_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            hi_only_q  <= hi_only_d;
        end
    end

    // A high-only response puts the upper word first; port 1 is unused then.
    assign push_inst0 = hi_only_q ? Icache_RspData[63:32] : Icache_RspData[31:0];
    assign push_pc0   = hi_only_q ? req_addr_q + ADDR_WIDTH'(4) : req_addr_q;
    assign pop_cnt    = Ctrl_Stall[1] ? 2'd0 : Decode_Take;

    fetch_queue #(
        .AW    (ADDR_WIDTH),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk           (clk),
        .rst           (rst),
        .clr_i         (redirect),
        .push_cnt_i    (push_cnt),
        .push_inst0_i  (push_inst0),
        .push_pc0_i    (push_pc0),
        .push_inst1_i  (Icache_RspData[63:32]),
        .push_pc1_i    (req_addr_q + ADDR_WIDTH'(4)),
        .pop_cnt_i     (pop_cnt),
        .head0_valid_o (Fetch_Valid_0),
        .head0_inst_o  (Fetch_Inst_0),
        .head0_pc_o    (Fetch_PC_0),
        .head1_valid_o (Fetch_Valid_1),
        .head1_inst_o  (Fetch_Inst_1),
        .head1_pc_o    (Fetch_PC_1),
        .count_o       (q_count)
    );

    assign Icache_StallReq = (q_count == '0) && !rsp_live;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, hand-written corner sequences and
// random traffic, all checked against a queue-based reference model.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    localparam int QD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Ctrl_Stall;
    logic        Csr_ExcpFlag, EX_BranchFlag;
    logic [31:0] Csr_ExcpPC, EX_BranchPC;
    logic        Fetch_Req;
    logic [31:0] Fetch_Addr;
    logic        Icache_Ready, Icache_RspValid;
    logic [63:0] Icache_RspData;
    logic        Icache_StallReq;
    logic        Fetch_Valid_0, Fetch_Valid_1;
    logic [31:0] Fetch_Inst_0, Fetch_Inst_1, Fetch_PC_0, Fetch_PC_1;
    logic [1:0]  Decode_Take;
    fetch_state_e dbg_state;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .Ctrl_Stall      (Ctrl_Stall),
        .Csr_ExcpFlag    (Csr_ExcpFlag),
        .Csr_ExcpPC      (Csr_ExcpPC),
        .EX_BranchFlag   (EX_BranchFlag),
        .EX_BranchPC     (EX_BranchPC),
        .Fetch_Req       (Fetch_Req),
        .Fetch_Addr      (Fetch_Addr),
        .Icache_Ready    (Icache_Ready),
        .Icache_RspValid (Icache_RspValid),
        .Icache_RspData  (Icache_RspData),
        .Icache_StallReq (Icache_StallReq),
        .Fetch_Valid_0   (Fetch_Valid_0),
        .Fetch_Valid_1   (Fetch_Valid_1),
        .Fetch_Inst_0    (Fetch_Inst_0),
        .Fetch_Inst_1    (Fetch_Inst_1),
        .Fetch_PC_0      (Fetch_PC_0),
        .Fetch_PC_1      (Fetch_PC_1),
        .Decode_Take     (Decode_Take),
        .dbg_state_o     (dbg_state)
    );

    typedef struct {
        logic [4:0]  stall;
        logic        excp;
        logic [31:0] epc;
        logic        br;
        logic [31:0] bpc;
        logic        ready;
        logic        rspv;
        logic [63:0] rdata;
        logic [1:0]  take;
    } in_t;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        v0;
        logic [31:0] i0;
        logic [31:0] p0;
        logic        v1;
        logic [31:0] i1;
        logic [31:0] p1;
        logic        sreq;
    } exp_t;

    typedef struct {
        in_t  in;
        exp_t ex;
    } vec_t;

    // Reference model: queue of {pc, inst} words plus the request bookkeeping.
    logic [63:0] exp_q[$];
    logic [31:0] m_pc, m_raddr;
    bit          m_out, m_disc, m_hi;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic in_t mi(logic [4:0] stall, logic excp, logic [31:0] epc, logic br,
                               logic [31:0] bpc, logic ready, logic rspv, logic [63:0] rdata,
                               logic [1:0] take);
        in_t v;
        v.stall = stall; v.excp = excp; v.epc = epc; v.br = br; v.bpc = bpc;
        v.ready = ready; v.rspv = rspv; v.rdata = rdata; v.take = take;
        return v;
    endfunction

    function automatic exp_t me(logic req, logic [31:0] addr, logic v0, logic [31:0] i0,
                                logic [31:0] p0, logic v1, logic [31:0] i1, logic [31:0] p1,
                                logic sreq);
        exp_t e;
        e.req = req; e.addr = addr; e.v0 = v0; e.i0 = i0; e.p0 = p0;
        e.v1 = v1; e.i1 = i1; e.p1 = p1; e.sreq = sreq;
        return e;
    endfunction

    function automatic in_t idle_in();
        return mi(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 2'd0);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_pc    = 32'h8000_0000;
        m_raddr = 32'h0;
        m_out   = 1'b0;
        m_disc  = 1'b0;
        m_hi    = 1'b0;
    endtask

    task automatic drive(input in_t v);
        Ctrl_Stall      = v.stall;
        Csr_ExcpFlag    = v.excp;
        Csr_ExcpPC      = v.epc;
        EX_BranchFlag   = v.br;
        EX_BranchPC     = v.bpc;
        Icache_Ready    = v.ready;
        Icache_RspValid = v.rspv;
        Icache_RspData  = v.rdata;
        Decode_Take     = v.take;
    endtask

    // One clock: drive after the edge, compare at the falling edge, advance the model at the edge.
    task automatic cycle(input in_t v, input bit use_tab, input exp_t t);
        logic        redir, e_req, e_sreq;
        logic [31:0] tgt, e_addr;
        int          n;
        drive(v);
        assert (int'(v.take) <= exp_q.size()) else $error("bench drove Decode_Take beyond valid words");
        @(negedge clk);
        redir  = v.excp | v.br;
        tgt    = v.excp ? v.epc : v.bpc;
        tgt[1:0] = 2'b00;
        e_req  = !m_out && (QD - exp_q.size()) >= 2 && !v.stall[0] && !redir;
        e_addr = {m_pc[31:3], 3'b000};
        e_sreq = (exp_q.size() == 0) && !(v.rspv && m_out && !m_disc);
        check("req", Fetch_Req, e_req);
        check("addr", Fetch_Addr, e_addr);
        check("valid0", Fetch_Valid_0, exp_q.size() >= 1);
        check("valid1", Fetch_Valid_1, exp_q.size() >= 2);
        if (exp_q.size() >= 1) check("word0", {Fetch_PC_0, Fetch_Inst_0}, exp_q[0]);
        if (exp_q.size() >= 2) check("word1", {Fetch_PC_1, Fetch_Inst_1}, exp_q[1]);
        check("stall_req", Icache_StallReq, e_sreq);
        if (use_tab) begin
            check("tab_req", Fetch_Req, t.req);
            check("tab_addr", Fetch_Addr, t.addr);
            check("tab_v0", Fetch_Valid_0, t.v0);
            check("tab_v1", Fetch_Valid_1, t.v1);
            check("tab_sreq", Icache_StallReq, t.sreq);
            if (t.v0) check("tab_w0", {Fetch_PC_0, Fetch_Inst_0}, {t.p0, t.i0});
            if (t.v1) check("tab_w1", {Fetch_PC_1, Fetch_Inst_1}, {t.p1, t.i1});
        end
        @(posedge clk);
        if (redir) begin
            exp_q.delete();
            if (m_out) begin
                if (v.rspv) begin
                    m_out  = 1'b0;
                    m_disc = 1'b0;
                end else begin
                    m_disc = 1'b1;
                end
            end
            m_pc = tgt;
        end else begin
            n = v.stall[1] ? 0 : int'(v.take);
            repeat (n) void'(exp_q.pop_front());
            if (m_out && v.rspv) begin
                if (!m_disc) begin
                    if (!m_hi) exp_q.push_back({m_raddr, v.rdata[31:0]});
                    exp_q.push_back({m_raddr + 32'd4, v.rdata[63:32]});
                end
                m_out  = 1'b0;
                m_disc = 1'b0;
            end
            if (e_req && v.ready) begin
                m_out   = 1'b1;
                m_hi    = m_pc[2];
                m_raddr = e_addr;
                m_pc    = e_addr + 32'd8;
            end
        end
        #1;
    endtask

    task automatic mcycle(input in_t v);
        cycle(v, 1'b0, me(0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"}, Fetch_Req, 1'b0);
        check({tag, "_v0"}, Fetch_Valid_0, 1'b0);
        check({tag, "_v1"}, Fetch_Valid_1, 1'b0);
        check({tag, "_sreq"}, Icache_StallReq, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab[10];
        in_t  v;
        int   lim;

        tab[0] = '{in: mi(0, 0, 0, 0, 0, 1, 0, 64'h0, 0),
                   ex: me(1, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 1)};
        tab[1] = '{in: mi(0, 0, 0, 0, 0, 0, 1, 64'h00000013_00000093, 0),
                   ex: me(0, 32'h8000_0008, 0, 0, 0, 0, 0, 0, 0)};
        tab[2] = '{in: mi(0, 0, 0, 0, 0, 0, 0, 64'h0, 0),
                   ex: me(1, 32'h8000_0008, 1, 32'h93, 32'h8000_0000, 1, 32'h13, 32'h8000_0004, 0)};
        tab[3] = '{in: mi(0, 0, 0, 0, 0, 1, 0, 64'h0, 2),
                   ex: me(1, 32'h8000_0008, 1, 32'h93, 32'h8000_0000, 1, 32'h13, 32'h8000_0004, 0)};
        tab[4] = '{in: mi(0, 0, 0, 1, 32'h8000_0104, 0, 0, 64'h0, 0),
                   ex: me(0, 32'h8000_0010, 0, 0, 0, 0, 0, 0, 1)};
        tab[5] = '{in: mi(0, 0, 0, 0, 0, 0, 1, 64'hDEADBEEF_CAFEF00D, 0),
                   ex: me(0, 32'h8000_0100, 0, 0, 0, 0, 0, 0, 1)};
        tab[6] = '{in: mi(0, 0, 0, 0, 0, 1, 0, 64'h0, 0),
                   ex: me(1, 32'h8000_0100, 0, 0, 0, 0, 0, 0, 1)};
        tab[7] = '{in: mi(0, 0, 0, 0, 0, 0, 1, 64'h11111111_22222222, 0),
                   ex: me(0, 32'h8000_0108, 0, 0, 0, 0, 0, 0, 0)};
        tab[8] = '{in: mi(0, 1, 32'h8000_0200, 1, 32'h8000_0300, 0, 0, 64'h0, 0),
                   ex: me(0, 32'h8000_0108, 1, 32'h1111_1111, 32'h8000_0104, 0, 0, 0, 0)};
        tab[9] = '{in: mi(0, 0, 0, 0, 0, 0, 0, 64'h0, 0),
                   ex: me(1, 32'h8000_0200, 0, 0, 0, 0, 0, 0, 1)};

        // Clock/reset
        rst = 1'b1;
        drive(idle_in());
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        check_reset_values("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors: first fetch, branch discard, redirect priority
        for (int i = 0; i < 10; i++) cycle(tab[i].in, 1'b1, tab[i].ex);

        // Fill the queue with no consumption, then free two entries
        mcycle(mi(0, 0, 0, 0, 0, 1, 0, 64'h0, 0));
        mcycle(mi(0, 0, 0, 0, 0, 0, 1, 64'hA1A1A1A1_A0A0A0A0, 0));
        mcycle(mi(0, 0, 0, 0, 0, 1, 0, 64'h0, 0));
        mcycle(mi(0, 0, 0, 0, 0, 0, 1, 64'hB1B1B1B1_B0B0B0B0, 0));
        repeat (3) mcycle(mi(0, 0, 0, 0, 0, 1, 0, 64'h0, 0));
        check("full_no_req", Fetch_Req, 1'b0);
        mcycle(mi(0, 0, 0, 0, 0, 0, 0, 64'h0, 2));
        check("reissue_req", Fetch_Req, 1'b1);
        check("reissue_addr", Fetch_Addr, 32'h8000_0210);

        // Stall both issue and dequeue with two words held
        mcycle(mi(5'b00011, 0, 0, 0, 0, 1, 0, 64'h0, 2));
        check("stall_no_req", Fetch_Req, 1'b0);
        check("stall_hold_pc0", Fetch_PC_0, 32'h8000_0208);
        check("stall_hold_inst1", Fetch_Inst_1, 32'hB1B1_B1B1);
        mcycle(mi(0, 0, 0, 0, 0, 0, 0, 64'h0, 2));

        // Starved with a request outstanding, then reset mid-request and a stale response
        mcycle(mi(0, 0, 0, 0, 0, 1, 0, 64'h0, 0));
        mcycle(mi(0, 0, 0, 0, 0, 0, 0, 64'h0, 0));
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #3;
        check_reset_values("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        mcycle(mi(0, 0, 0, 0, 0, 0, 1, 64'h5555_5555_6666_6666, 0));
        mcycle(mi(0, 0, 0, 0, 0, 0, 0, 64'h0, 0));

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            v = idle_in();
            if ($urandom_range(0, 9) == 0) v.stall = 5'($urandom);
            v.excp  = ($urandom_range(0, 29) == 0);
            v.br    = ($urandom_range(0, 14) == 0);
            v.epc   = {8'h80, 24'($urandom)};
            v.bpc   = {8'h80, 24'($urandom)};
            v.ready = 1'($urandom_range(0, 1));
            v.rspv  = m_out ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
            v.rdata = {$urandom, $urandom};
            lim     = (exp_q.size() < 2) ? exp_q.size() : 2;
            v.take  = 2'($urandom_range(0, lim));
            mcycle(v);
        end

        drive(idle_in());
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch front end of the dual-issue core. It owns the fetch PC, issues 8-byte aligned requests to the I-cache, and buffers returned 32-bit instruction words in a small queue that feeds the two decode slots. It applies redirects from the branch unit and CSR exception logic, and honours the stall vector from the pipeline controller. It drives `Icache_StallReq` back into that controller.

## Interface
- `ADDR_WIDTH`, 32: PC and address width (shared `ADDR_WIDTH`).
- `RESET_PC`, 32'h8000_0000: first fetch address after reset.
- `QDEPTH`, 4: instruction-queue depth in 32-bit words. Power of two, ≥4.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-high reset.
- `Ctrl_Stall`  in  5  stall vector. Bit0 blocks request issue. Bit1 blocks dequeue.
- `Csr_ExcpFlag`  in  1  exception/trap redirect.
- `Csr_ExcpPC`  in  ADDR_WIDTH  trap target.
- `EX_BranchFlag`  in  1  branch/jump redirect.
- `EX_BranchPC`  in  ADDR_WIDTH  branch target.
- `Fetch_Req`  out  1  request valid.
- `Fetch_Addr`  out  ADDR_WIDTH  8-byte aligned request address.
- `Icache_Ready`  in  1  request accepted when high with `Fetch_Req`.
- `Icache_RspValid`  in  1  response data valid (one cycle).
- `Icache_RspData`  in  64  two words; low word is at `Fetch_Addr`+0.
- `Icache_StallReq`  out  1  fetch starved (to controller).
- `Fetch_Valid_0/1`  out  1 each  queue head / head+1 valid.
- `Fetch_Inst_0/1`  out  32 each  instruction words.
- `Fetch_PC_0/1`  out  ADDR_WIDTH each  word PCs.
- `Decode_Take`  in  2  words consumed this cycle (0,1,2).

## Operation
- Redirect target bits [1:0] are forced to zero.
- Redirect priority is `Csr_ExcpFlag` over `EX_BranchFlag`.
- PC register `pc`:
  - Request address is `{pc[ADDR_WIDTH-1:3],3'b000}`.
  - On request acceptance, `pc` becomes aligned address + 8.
  - The issued `pc[2]` is recorded. If it was 1, only the high word is enqueued.
- At most one outstanding request.
- `Fetch_Req` is asserted only when all of the following hold:
  - no request is outstanding;
  - free entries ≥ 2;
  - `Ctrl_Stall[0]` is 0;
  - no redirect is present this cycle.
- `Fetch_Req` and `Fetch_Addr` hold stable until `Icache_Ready`.
- Queue behaviour:
  - A response pushes 1 or 2 words, each tagged with its PC.
  - Pop count is `Decode_Take`. It is forced to 0 when `Ctrl_Stall[1]` is 1.
  - `Decode_Take` must never exceed the number of valid words. The bench asserts this.
  - Push and pop may occur in the same cycle. Count updates by push − pop.
- On redirect:
  - `pc` ← target and the queue is emptied.
  - An in-flight request is marked discard, and its response is dropped without pushing.
  - A redirect arriving in the same cycle as a response also drops that response.
  - A redirect coincident with a pop has the pop ignored.
- `Icache_StallReq` = queue empty AND NOT (`Icache_RspValid` with a non-discarded response). Driven from registers plus `Icache_RspValid` only.

## Timing
- Reset values:
  - `pc` = `RESET_PC`, queue empty, no outstanding request, discard flag 0.
  - `Fetch_Req` = 0, all `Fetch_Valid_*` = 0, `Icache_StallReq` = 1.
- `Fetch_Req` asserts on the first cycle after reset deassertion.
- Response to decode: words pushed at edge N are visible on `Fetch_*_0/1` in cycle N+1. There is no bypass.
- Redirect to new request:
  - A flag in cycle N gives `Fetch_Req` with the target in cycle N+1 if nothing is outstanding.
  - Otherwise the request follows the cycle after the discarded response returns.
- Reset mid-request: the outstanding request is forgotten. A stale response arriving after reset is ignored because the outstanding flag is 0.
- Queue pointers wrap modulo `QDEPTH`. Full-condition issue is blocked by the free-entry check, so there is never an overflow.

## Structure
- `RESET_PC` and `FETCH_QDEPTH` defaults belong in the shared `Define.v` alongside `ADDR_WIDTH`.
- Sub-module `fetch_queue`: circular FIFO with 2-write and 2-read ports, synchronous clear, and count output.
- Top level: PC/request FSM with states IDLE, WAIT_RSP, WAIT_RSP_DISCARD, plus redirect muxing.

## Test plan
- Reset release, `Icache_Ready`=1, response one cycle later with data 0x00000013_00000093 → `Fetch_PC_0`=0x80000000 `Inst_0`=0x00000093, `PC_1`=0x80000004 `Inst_1`=0x00000013.
- `EX_BranchFlag` with PC 0x80000104 while a request is outstanding → the response is dropped. The next request has `Fetch_Addr`=0x80000100, and only word PC 0x80000104 is enqueued.
- `Csr_ExcpFlag` (0x80000200) and `EX_BranchFlag` (0x80000300) in the same cycle → next `Fetch_Addr`=0x80000200.
- Fill the queue with `Decode_Take`=0 → no `Fetch_Req` while free < 2. Then `Decode_Take`=2 → a request reissues the next cycle.
- `Ctrl_Stall`=5'b00011 with queue holding 2 words and `Decode_Take`=2 → no pop, no request, outputs held.
- Empty queue with request outstanding → `Icache_StallReq`=1, dropping in the cycle `Icache_RspValid` is high.
